x2c_wr_arb: RTL and testbench
=============================

# x2c_wr_arb

Two-requester, packet-granular, round-robin write arbiter for the x2c transmit buffer (x2c_ctrl). It merges two 256-bit word streams (e.g. two host DMA queues) onto the single x2c write interface. It drives x_we/data_in/ctrl_in, and issues x_byte_cnt/x_bcnt_we with each packet's last word. A grant is issued only when the buffer has room for a maximum-size packet, using internal occupancy tracking of the x2c data and byte-count FIFOs.

## Interface
- DATA_DEPTH, 1024: x2c data/ctrl FIFO depth in words.
- BCNT_DEPTH, 256: x2c byte-count FIFO depth in entries.
- MAX_PKT_WORDS, 300: worst-case packet length in 256-bit words (9600-byte jumbo).
- clk  in  1  single clock for arbiter and x2c.
- reset_  in  1  synchronous, active-low reset.
- rq_req  in  2  per requester: packet pending; held high until its eop beat is accepted.
- rq_vld  in  2  per requester: data word valid.
- rq_eop  in  2  per requester: current word is the last of the packet.
- rq0_data, rq1_data  in  256 each  word data.
- rq0_ctrl, rq1_ctrl  in  32 each  word ctrl.
- rq0_bcnt, rq1_bcnt  in  32 each  packet byte-count descriptor (x2c format), stable from request through eop.
- rq_rdy  out  2  per requester: word accepted when rq_vld & rq_rdy.
- rq_gnt  out  2  one-hot current owner (00 when none).
- x_rd_en  in  1  tap of x2c data FIFO read enable.
- x_bcnt_rd  in  1  tap of x2c byte-count FIFO read enable.
- x_we  out  1  data/ctrl write enable to x2c.
- data_out  out  256  to x2c data_in.
- ctrl_out  out  32  to x2c ctrl_in.
- x_byte_cnt  out  32  to x2c.
- x_bcnt_we  out  1  byte-count write enable.

## Operation
- States (one-hot): IDLE, XFER, GAP.
- IDLE: eligible = rq_req & space_ok. space_ok = (DATA_DEPTH - data_occ >= MAX_PKT_WORDS) & (bcnt_occ < BCNT_DEPTH).
  - If any requester is eligible, grant round-robin: the requester not granted last wins when both request. The last-grant pointer resets to 1, so requester 0 wins first.
  - The chosen requester's rq_gnt bit is set; go to XFER.
- XFER: rq_rdy[g] = 1. Each accepted word is registered onto data_out/ctrl_out with x_we = 1 on the next cycle.
  - On the eop accept, x_byte_cnt = rqg_bcnt and x_bcnt_we = 1, in the same output cycle as the last x_we.
  - The byte count is never written before the packet's last data word, so x2c cannot start reading an incomplete packet.
  - rq_vld low mid-packet: no write; remain in XFER, unbounded.
  - rq_req of the non-owner is ignored until return to IDLE.
  - rq_eop without rq_vld has no effect.
- GAP: rq_rdy = 0 and rq_gnt cleared; update the last-grant pointer; go to IDLE.
- data_occ (11 bits): +1 per accepted word (counted at accept, so pipeline words are included); -1 per x_rd_en. Both in one cycle: net 0.
- bcnt_occ (9 bits): +1 per eop accept; -1 per x_bcnt_rd; simultaneous gives net 0. Neither counter wraps. Underflow (read while 0) saturates at 0.
- Idle outputs: data_out = 256'h0707…07 (all bytes 8'h07), ctrl_out = 32'hffffffff, x_byte_cnt = 0, x_we = x_bcnt_we = 0.
- Reset (any cycle, including mid-packet): all outputs take their idle values and rq_rdy = rq_gnt = 00. State goes to IDLE, counters to 0, pointer to 1. x2c is reset by the same reset_, so a partial packet is discarded with it.

## Timing
- Request sampled in IDLE at cycle N: rq_gnt and rq_rdy high at N+1.
- Word accepted at cycle k: x_we/data_out/ctrl_out at k+1. Last-word x_bcnt_we is also at k+1.
- Eop accepted at k: GAP at k+1, IDLE at k+2, next grant and rq_rdy at k+3. Minimum inter-packet bubble is 2 idle cycles.
- space_ok is evaluated in IDLE only; a grant is never revoked mid-packet.
- rq_rdy is a registered state decode. It does not depend combinationally on rq_vld.

## Test plan
- Single packet, requester 0: 3 words, rq0_bcnt = 32'h0000_0060. Required: x_we high 3 consecutive cycles starting one cycle after the first accept. x_bcnt_we is high only on the third, with x_byte_cnt = 32'h0000_0060. Then data_out returns to all 07, ctrl_out to ffffffff.
- Both requesters continuously request 2-word packets. Required: grants alternate 0,1,0,1. Each eop is followed by exactly 2 cycles with rq_rdy = 00.
- rq_vld toggling 1,0,0,1,1 during a 3-word packet. Required: x_we mirrors accepts with 1-cycle delay, no extra writes, single x_bcnt_we with the last word.
- Preload data_occ to 725 with x_rd_en never asserted, then request. Required: no grant, because 1024 - 725 < 300. Pulse x_rd_en once (occ 724): grant appears 2 cycles later. A simultaneous accept and x_rd_en leaves occ unchanged.
- 256 packets accepted with x_bcnt_rd held low. Required: the next request is not granted. One x_bcnt_rd re-enables the grant.
- Assert reset_ low for 1 cycle mid-packet on requester 1. Required: next cycle x_we = 0, rq_gnt = 00, outputs at idle values, counters 0. The first subsequent simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/x2c_wr_arb_if.sv
// Bundle of requester, x2c write and FIFO-tap signals for the x2c write arbiter.
// master = requesters/x2c side, slave = the arbiter.
interface x2c_wr_arb_if;
    logic [1:0]   rq_req;
    logic [1:0]   rq_vld;
    logic [1:0]   rq_eop;
    logic [255:0] rq0_data;
    logic [255:0] rq1_data;
    logic [31:0]  rq0_ctrl;
    logic [31:0]  rq1_ctrl;
    logic [31:0]  rq0_bcnt;
    logic [31:0]  rq1_bcnt;
    logic [1:0]   rq_rdy;
    logic [1:0]   rq_gnt;
    logic         x_rd_en;
    logic         x_bcnt_rd;
    logic         x_we;
    logic [255:0] data_out;
    logic [31:0]  ctrl_out;
    logic [31:0]  x_byte_cnt;
    logic         x_bcnt_we;

    modport master (
        output rq_req, rq_vld, rq_eop, rq0_data, rq1_data, rq0_ctrl, rq1_ctrl,
               rq0_bcnt, rq1_bcnt, x_rd_en, x_bcnt_rd,
        input  rq_rdy, rq_gnt, x_we, data_out, ctrl_out, x_byte_cnt, x_bcnt_we
    );

    modport slave (
        input  rq_req, rq_vld, rq_eop, rq0_data, rq1_data, rq0_ctrl, rq1_ctrl,
               rq0_bcnt, rq1_bcnt, x_rd_en, x_bcnt_rd,
        output rq_rdy, rq_gnt, x_we, data_out, ctrl_out, x_byte_cnt, x_bcnt_we
    );
endinterface

// File: rtl/x2c_wr_arb.sv
// Two-requester packet-granular round-robin write arbiter feeding the x2c
// transmit buffer; grants only when x2c can absorb a maximum-size packet.
module x2c_wr_arb #(
    parameter int DATA_DEPTH    = 1024,
    parameter int BCNT_DEPTH    = 256,
    parameter int MAX_PKT_WORDS = 300
) (
    input logic          clk,
    input logic          reset_,
    x2c_wr_arb_if.slave  bus
);
    localparam int DOW = $clog2(DATA_DEPTH + 1);
    localparam int BOW = $clog2(BCNT_DEPTH + 1);
    localparam logic [DOW-1:0] DATA_LIMIT = DOW'(DATA_DEPTH - MAX_PKT_WORDS);
    localparam logic [BOW-1:0] BCNT_LIMIT = BOW'(BCNT_DEPTH);
    localparam logic [255:0]   IDLE_DATA  = {32{8'h07}};
    localparam logic [31:0]    IDLE_CTRL  = '1;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        XFER = 3'b010,
        GAP  = 3'b100
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      gnt;
    logic            owner;
    logic            last;
    logic [DOW-1:0]  data_occ;
    logic [BOW-1:0]  bcnt_occ;

    logic            space_ok;
    logic [1:0]      elig;
    logic            pick;
    logic [1:0]      rdy;
    logic            acc;
    logic            acc_eop;
    logic [255:0]    sel_data;
    logic [31:0]     sel_ctrl;
    logic [31:0]     sel_bcnt;

    logic            we_q;
    logic            bwe_q;
    logic [255:0]    data_q;
    logic [31:0]     ctrl_q;
    logic [31:0]     bcnt_q;

    // Ready is a pure decode of registered state, never of rq_vld.
    always_comb begin
        space_ok = (data_occ <= DATA_LIMIT) && (bcnt_occ < BCNT_LIMIT);
        elig     = bus.rq_req & {2{space_ok}};
        pick     = (elig == 2'b11) ? ~last : elig[1];
        rdy      = (state == XFER) ? gnt : 2'b00;
        acc      = |(bus.rq_vld & rdy);
        acc_eop  = |(bus.rq_vld & rdy & bus.rq_eop);
        sel_data = owner ? bus.rq1_data : bus.rq0_data;
        sel_ctrl = owner ? bus.rq1_ctrl : bus.rq0_ctrl;
        sel_bcnt = owner ? bus.rq1_bcnt : bus.rq0_bcnt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|elig) state_nxt = XFER;
            XFER:    if (acc_eop) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            gnt   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (|elig) begin
                    owner <= pick;
                    gnt   <= pick ? 2'b10 : 2'b01;
                end
                XFER: if (acc_eop) gnt <= '0;
                GAP:  last <= owner;
                default: gnt <= '0;
            endcase
        end
    end

    // Occupancy counts at accept, so words still in the output stage are included.
    always_ff @(posedge clk) begin
        if (!reset_)
            data_occ <= '0;
        else if (acc && !bus.x_rd_en)
            data_occ <= data_occ + DOW'(1);
        else if (!acc && bus.x_rd_en && (data_occ != '0))
            data_occ <= data_occ - DOW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_)
            bcnt_occ <= '0;
        else if (acc_eop && !bus.x_bcnt_rd)
            bcnt_occ <= bcnt_occ + BOW'(1);
        else if (!acc_eop && bus.x_bcnt_rd && (bcnt_occ != '0))
            bcnt_occ <= bcnt_occ - BOW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_ || !acc) begin
            we_q   <= 1'b0;
            bwe_q  <= 1'b0;
            data_q <= IDLE_DATA;
            ctrl_q <= IDLE_CTRL;
            bcnt_q <= '0;
        end else begin
            we_q   <= 1'b1;
            bwe_q  <= acc_eop;
            data_q <= sel_data;
            ctrl_q <= sel_ctrl;
            bcnt_q <= acc_eop ? sel_bcnt : '0;
        end
    end

    assign bus.rq_rdy     = rdy;
    assign bus.rq_gnt     = gnt;
    assign bus.x_we       = we_q;
    assign bus.x_bcnt_we  = bwe_q;
    assign bus.data_out   = data_q;
    assign bus.ctrl_out   = ctrl_q;
    assign bus.x_byte_cnt = bcnt_q;
endmodule

// File: tb/tb_x2c_wr_arb.sv
// Directed self-checking bench for x2c_wr_arb.
module tb_x2c_wr_arb;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [255:0] IDLE_DATA = {32{8'h07}};
    localparam logic [31:0]  IDLE_CTRL = 32'hffff_ffff;

    x2c_wr_arb_if bus ();

    x2c_wr_arb #(
        .DATA_DEPTH    (1024),
        .BCNT_DEPTH    (256),
        .MAX_PKT_WORDS (300)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [255:0] data_of(input int r, input int w);
        logic [31:0] t;
        t = {8'hA0 + 8'(r), 8'h5A, 16'(w)};
        return {8{t}};
    endfunction

    function automatic logic [31:0] ctrl_of(input int r, input int w);
        return 32'hC000_0000 + 32'(r * 65536) + 32'(w);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.rq_req = '0; bus.rq_vld = '0; bus.rq_eop = '0;
        bus.rq0_data = '0; bus.rq1_data = '0;
        bus.rq0_ctrl = '0; bus.rq1_ctrl = '0;
        bus.rq0_bcnt = '0; bus.rq1_bcnt = '0;
        bus.x_rd_en = 1'b0; bus.x_bcnt_rd = 1'b0;
    endtask

    task automatic apply_reset();
        clr_inputs();
        reset_ = 1'b0;
        step();
        step();
        reset_ = 1'b1;
    endtask

    task automatic set_word(input int r, input int w, input logic v, input logic e);
        bus.rq_vld[r] = v;
        bus.rq_eop[r] = e;
        if (r == 0) begin
            bus.rq0_data = data_of(0, w); bus.rq0_ctrl = ctrl_of(0, w);
        end else begin
            bus.rq1_data = data_of(1, w); bus.rq1_ctrl = ctrl_of(1, w);
        end
    endtask

    // Drives one complete packet from requester r; ok=0 if no grant arrives.
    task automatic push_pkt(input int r, input int n, input logic [31:0] bc, output bit ok);
        int t = 0;
        ok = 1'b1;
        if (r == 0) bus.rq0_bcnt = bc; else bus.rq1_bcnt = bc;
        bus.rq_req[r] = 1'b1;
        bus.rq_vld[r] = 1'b0;
        while (!bus.rq_gnt[r] && t < 20) begin
            step();
            t++;
        end
        if (!bus.rq_gnt[r]) begin
            ok = 1'b0;
            bus.rq_req[r] = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            set_word(r, w, 1'b1, w == n - 1);
            step();
        end
        bus.rq_req[r] = 1'b0;
        bus.rq_vld[r] = 1'b0;
        bus.rq_eop[r] = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        reset_ = 1'b0;
        step();
        n_vec++; if (bus.x_we !== 1'b0) begin n_err++; $display("FAIL reset_x_we: got %b exp 0", bus.x_we); end
        n_vec++; if (bus.x_bcnt_we !== 1'b0) begin n_err++; $display("FAIL reset_bcnt_we: got %b exp 0", bus.x_bcnt_we); end
        n_vec++; if (bus.data_out !== IDLE_DATA) begin n_err++; $display("FAIL reset_data: got %h exp %h", bus.data_out, IDLE_DATA); end
        n_vec++; if (bus.ctrl_out !== IDLE_CTRL) begin n_err++; $display("FAIL reset_ctrl: got %h exp %h", bus.ctrl_out, IDLE_CTRL); end
        n_vec++; if (bus.x_byte_cnt !== 32'h0) begin n_err++; $display("FAIL reset_byte_cnt: got %h exp 0", bus.x_byte_cnt); end
        n_vec++; if (bus.rq_rdy !== 2'b00) begin n_err++; $display("FAIL reset_rdy: got %b exp 00", bus.rq_rdy); end
        n_vec++; if (bus.rq_gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b exp 00", bus.rq_gnt); end
        reset_ = 1'b1;
    endtask

    task automatic test_single_pkt();
        apply_reset();
        bus.rq0_bcnt = 32'h0000_0060;
        bus.rq_req = 2'b01;
        step();
        n_vec++; if (bus.rq_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b exp 01", bus.rq_gnt); end
        n_vec++; if (bus.rq_rdy !== 2'b01) begin n_err++; $display("FAIL single_rdy: got %b exp 01", bus.rq_rdy); end
        n_vec++; if (bus.x_we !== 1'b0) begin n_err++; $display("FAIL single_we_pre: got %b exp 0", bus.x_we); end
        for (int w = 0; w < 3; w++) begin
            set_word(0, w, 1'b1, w == 2);
            step();
            n_vec++; if (bus.x_we !== 1'b1) begin n_err++; $display("FAIL single_we[%0d]: got %b exp 1", w, bus.x_we); end
            n_vec++; if (bus.data_out !== data_of(0, w)) begin n_err++; $display("FAIL single_data[%0d]: got %h exp %h", w, bus.data_out, data_of(0, w)); end
            n_vec++; if (bus.ctrl_out !== ctrl_of(0, w)) begin n_err++; $display("FAIL single_ctrl[%0d]: got %h exp %h", w, bus.ctrl_out, ctrl_of(0, w)); end
            n_vec++; if (bus.x_bcnt_we !== (w == 2)) begin n_err++; $display("FAIL single_bcnt_we[%0d]: got %b exp %b", w, bus.x_bcnt_we, w == 2); end
            n_vec++; if (bus.x_byte_cnt !== ((w == 2) ? 32'h60 : 32'h0)) begin n_err++; $display("FAIL single_byte_cnt[%0d]: got %h", w, bus.x_byte_cnt); end
        end
        clr_inputs();
        step();
        n_vec++; if (bus.x_we !== 1'b0) begin n_err++; $display("FAIL single_we_post: got %b exp 0", bus.x_we); end
        n_vec++; if (bus.data_out !== IDLE_DATA) begin n_err++; $display("FAIL single_data_post: got %h exp %h", bus.data_out, IDLE_DATA); end
        n_vec++; if (bus.ctrl_out !== IDLE_CTRL) begin n_err++; $display("FAIL single_ctrl_post: got %h exp %h", bus.ctrl_out, IDLE_CTRL); end
        n_vec++; if (bus.rq_rdy !== 2'b00) begin n_err++; $display("FAIL single_rdy_post: got %b exp 00", bus.rq_rdy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int         widx [2] = '{0, 0};
        int         ng = 0;
        int         zrun = 0;
        bit         started = 1'b0;
        logic [1:0] prev_gnt = 2'b00;
        logic [1:0] acc;
        apply_reset();
        bus.rq0_bcnt = 32'h40;
        bus.rq1_bcnt = 32'h40;
        bus.rq_req = 2'b11;
        for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
            for (int r = 0; r < 2; r++) set_word(r, widx[r], 1'b1, widx[r] == 1);
            acc = bus.rq_rdy & bus.rq_vld;
            step();
            for (int r = 0; r < 2; r++) if (acc[r]) widx[r] = 1 - widx[r];
            if (bus.rq_gnt != 2'b00 && prev_gnt == 2'b00) begin
                n_vec++; if (bus.rq_gnt !== exp_g[ng]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b exp %b", ng, bus.rq_gnt, exp_g[ng]); end
                if (started) begin
                    n_vec++; if (zrun !== 2) begin n_err++; $display("FAIL rr_bubble[%0d]: got %0d exp 2", ng, zrun); end
                end
                started = 1'b1;
                ng++;
            end
            zrun = (bus.rq_rdy == 2'b00) ? zrun + 1 : 0;
            prev_gnt = bus.rq_gnt;
        end
        n_vec++; if (ng !== 4) begin n_err++; $display("FAIL rr_grant_count: got %0d exp 4", ng); end
        clr_inputs();
    endtask

    task automatic test_vld_toggle();
        logic pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ebwe [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   w = 0;
        apply_reset();
        bus.rq0_bcnt = 32'h0000_0048;
        bus.rq_req = 2'b01;
        step();
        n_vec++; if (bus.rq_gnt !== 2'b01) begin n_err++; $display("FAIL tog_gnt: got %b exp 01", bus.rq_gnt); end
        for (int i = 0; i < 5; i++) begin
            // eop driven high while vld is low must be ignored
            set_word(0, w, pat[i], pat[i] ? (w == 2) : 1'b1);
            step();
            n_vec++; if (bus.x_we !== pat[i]) begin n_err++; $display("FAIL tog_we[%0d]: got %b exp %b", i, bus.x_we, pat[i]); end
            n_vec++; if (bus.x_bcnt_we !== ebwe[i]) begin n_err++; $display("FAIL tog_bcnt_we[%0d]: got %b exp %b", i, bus.x_bcnt_we, ebwe[i]); end
            if (pat[i]) begin
                n_vec++; if (bus.data_out !== data_of(0, w)) begin n_err++; $display("FAIL tog_data[%0d]: got %h exp %h", i, bus.data_out, data_of(0, w)); end
                w++;
            end
        end
        n_vec++; if (bus.x_byte_cnt !== 32'h48) begin n_err++; $display("FAIL tog_byte_cnt: got %h exp 48", bus.x_byte_cnt); end
        clr_inputs();
        step();
        n_vec++; if (bus.x_we !== 1'b0) begin n_err++; $display("FAIL tog_extra_we: got %b exp 0", bus.x_we); end
        n_vec++; if (bus.rq_rdy !== 2'b00) begin n_err++; $display("FAIL tog_rdy_post: got %b exp 00", bus.rq_rdy); end
    endtask

    task automatic test_space_limit();
        bit ok0, ok1, ok2;
        apply_reset();
        push_pkt(0, 300, 32'd9600, ok0);
        push_pkt(1, 300, 32'd9600, ok1);
        push_pkt(0, 125, 32'd4000, ok2);
        n_vec++; if ({ok0, ok1, ok2} !== 3'b111) begin n_err++; $display("FAIL space_preload: got %b exp 111", {ok0, ok1, ok2}); end
        step();
        step();
        n_vec++; if (dut.data_occ !== 11'd725) begin n_err++; $display("FAIL space_occ725: got %0d exp 725", dut.data_occ); end
        bus.rq_req = 2'b01;
        repeat (6) step();
        n_vec++; if (bus.rq_gnt !== 2'b00) begin n_err++; $display("FAIL space_blocked: got %b exp 00", bus.rq_gnt); end
        bus.x_rd_en = 1'b1;
        step();
        bus.x_rd_en = 1'b0;
        n_vec++; if (bus.rq_gnt !== 2'b00) begin n_err++; $display("FAIL space_early_gnt: got %b exp 00", bus.rq_gnt); end
        step();
        n_vec++; if (bus.rq_gnt !== 2'b01) begin n_err++; $display("FAIL space_gnt: got %b exp 01", bus.rq_gnt); end
        bus.rq0_bcnt = 32'h20;
        set_word(0, 0, 1'b1, 1'b1);
        bus.x_rd_en = 1'b1;
        step();
        clr_inputs();
        n_vec++; if (dut.data_occ !== 11'd724) begin n_err++; $display("FAIL space_occ_net0: got %0d exp 724", dut.data_occ); end
        n_vec++; if (bus.x_bcnt_we !== 1'b1) begin n_err++; $display("FAIL space_bcnt_we: got %b exp 1", bus.x_bcnt_we); end
    endtask

    task automatic test_bcnt_limit();
        bit ok;
        bit allok = 1'b1;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            push_pkt(0, 1, 32'h20, ok);
            allok &= ok;
        end
        n_vec++; if (allok !== 1'b1) begin n_err++; $display("FAIL bcnt_fill: got %b exp 1", allok); end
        step();
        step();
        n_vec++; if (dut.bcnt_occ !== 9'd256) begin n_err++; $display("FAIL bcnt_occ256: got %0d exp 256", dut.bcnt_occ); end
        bus.rq_req = 2'b01;
        repeat (6) step();
        n_vec++; if (bus.rq_gnt !== 2'b00) begin n_err++; $display("FAIL bcnt_blocked: got %b exp 00", bus.rq_gnt); end
        bus.x_bcnt_rd = 1'b1;
        step();
        bus.x_bcnt_rd = 1'b0;
        step();
        n_vec++; if (bus.rq_gnt !== 2'b01) begin n_err++; $display("FAIL bcnt_regrant: got %b exp 01", bus.rq_gnt); end
        clr_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.rq1_bcnt = 32'h80;
        bus.rq_req = 2'b10;
        step();
        n_vec++; if (bus.rq_gnt !== 2'b10) begin n_err++; $display("FAIL rmid_gnt: got %b exp 10", bus.rq_gnt); end
        set_word(1, 0, 1'b1, 1'b0);
        step();
        n_vec++; if (bus.x_we !== 1'b1) begin n_err++; $display("FAIL rmid_we: got %b exp 1", bus.x_we); end
        set_word(1, 1, 1'b1, 1'b0);
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
        clr_inputs();
        n_vec++; if (bus.x_we !== 1'b0) begin n_err++; $display("FAIL rmid_x_we: got %b exp 0", bus.x_we); end
        n_vec++; if (bus.rq_gnt !== 2'b00) begin n_err++; $display("FAIL rmid_gnt_clr: got %b exp 00", bus.rq_gnt); end
        n_vec++; if (bus.rq_rdy !== 2'b00) begin n_err++; $display("FAIL rmid_rdy: got %b exp 00", bus.rq_rdy); end
        n_vec++; if (bus.data_out !== IDLE_DATA) begin n_err++; $display("FAIL rmid_data: got %h exp %h", bus.data_out, IDLE_DATA); end
        n_vec++; if (bus.ctrl_out !== IDLE_CTRL) begin n_err++; $display("FAIL rmid_ctrl: got %h exp %h", bus.ctrl_out, IDLE_CTRL); end
        n_vec++; if (bus.x_bcnt_we !== 1'b0) begin n_err++; $display("FAIL rmid_bcnt_we: got %b exp 0", bus.x_bcnt_we); end
        n_vec++; if (dut.data_occ !== 11'd0) begin n_err++; $display("FAIL rmid_data_occ: got %0d exp 0", dut.data_occ); end
        n_vec++; if (dut.bcnt_occ !== 9'd0) begin n_err++; $display("FAIL rmid_bcnt_occ: got %0d exp 0", dut.bcnt_occ); end
        bus.rq_req = 2'b11;
        step();
        n_vec++; if (bus.rq_gnt !== 2'b01) begin n_err++; $display("FAIL rmid_first_gnt: got %b exp 01", bus.rq_gnt); end
        clr_inputs();
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_vld_toggle();
        test_space_limit();
        test_bcnt_limit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
